// File: rtl/jclk_pkg.sv
// State encoding and default constants for the operator-controlled slow clock.
package jclk_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStopping,
        StStep
    } jclk_state_e;

    localparam int unsigned BaseHalfDefault   = 50000000;
    localparam int unsigned StepCyclesDefault = 4;
    localparam int unsigned CwDefault         = 26;

endpackage

// File: rtl/jclk_half_timer.sv
// Loadable down-counter that times one SCLK half-phase of half_i CLK cycles.
module jclk_half_timer
    import jclk_pkg::*;
#(
    parameter int unsigned CW = CwDefault
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [CW-1:0] half_i,
    output logic          done_o
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= half_i - CW'(1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Rests at zero between phases, so done also reads high while the controller idles.
    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/jclk_ctrl.sv
// Run/halt/single-step controller producing the registered slow clock SCLK for jclock.
module jclk_ctrl
    import jclk_pkg::*;
#(
    parameter int unsigned BASE_HALF   = BaseHalfDefault,
    parameter int unsigned STEP_CYCLES = StepCyclesDefault,
    parameter int unsigned CW          = CwDefault
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       RUN_CLICK,
    input  logic       STEP_CLICK,
    input  logic       HALT,
    input  logic [3:0] SPEED,
    output logic       SCLK,
    output logic       TICK,
    output logic       RUNNING,
    output logic       STEPPING
);

    localparam int unsigned SW = $clog2(STEP_CYCLES + 1);
    localparam logic [CW-1:0] BaseHalfW = CW'(BASE_HALF);

    jclk_state_e   state_q;
    logic          sclk_q, tick_q, running_q, stepping_q;
    logic [SW-1:0] step_q;
    logic [CW-1:0] shifted, half;
    logic          done, rise, fall, stop_req, low_end;

    assign shifted = BaseHalfW >> SPEED;
    assign half    = (shifted == '0) ? CW'(1) : shifted;

    // rise/fall mark the edges where a new half-phase begins; the timer reloads on both.
    always_comb begin
        stop_req = RUN_CLICK | HALT;
        low_end  = done & ~sclk_q;
        fall     = done & sclk_q;
        rise     = 1'b0;
        unique case (state_q)
            StIdle:     rise = STEP_CLICK | (RUN_CLICK & ~HALT);
            StRun:      rise = low_end & ~stop_req;
            StStopping: rise = 1'b0;
            StStep:     rise = low_end & (step_q != SW'(1));
            default:    rise = 1'b0;
        endcase
    end

    jclk_half_timer #(
        .CW(CW)
    ) u_half_timer (
        .clk_i (CLK),
        .rst_ni(RESETN),
        .load_i(rise | fall),
        .half_i(half),
        .done_o(done)
    );

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q    <= StIdle;
            sclk_q     <= 1'b0;
            tick_q     <= 1'b0;
            running_q  <= 1'b0;
            stepping_q <= 1'b0;
            step_q     <= '0;
        end else begin
            tick_q <= rise;
            if (rise) begin
                sclk_q <= 1'b1;
            end else if (fall) begin
                sclk_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (STEP_CLICK) begin
                        state_q    <= StStep;
                        stepping_q <= 1'b1;
                        step_q     <= SW'(STEP_CYCLES);
                    end else if (RUN_CLICK && !HALT) begin
                        state_q   <= StRun;
                        running_q <= 1'b1;
                    end
                end
                StRun: begin
                    // A stop landing on the last low cycle ends here rather than starting a pulse.
                    if (stop_req) begin
                        if (low_end) begin
                            state_q   <= StIdle;
                            running_q <= 1'b0;
                        end else begin
                            state_q <= StStopping;
                        end
                    end
                end
                StStopping: begin
                    if (low_end) begin
                        state_q   <= StIdle;
                        running_q <= 1'b0;
                    end
                end
                StStep: begin
                    if (low_end) begin
                        step_q <= step_q - SW'(1);
                        if (step_q == SW'(1)) begin
                            state_q    <= StIdle;
                            stepping_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    running_q  <= 1'b0;
                    stepping_q <= 1'b0;
                end
            endcase
        end
    end

    assign SCLK     = sclk_q;
    assign TICK     = tick_q;
    assign RUNNING  = running_q;
    assign STEPPING = stepping_q;

endmodule

// File: tb/tb_jclk_ctrl.sv
// Scoreboard bench: a timeline model predicts every SCLK half-phase; a monitor measures them.
module tb_jclk_ctrl;

    localparam int BASE  = 16;
    localparam int STEPS = 4;
    localparam int SLEN  = 256;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    logic       CLK = 1'b0;
    logic       RESETN, RUN_CLICK, STEP_CLICK, HALT;
    logic [3:0] SPEED;
    logic       SCLK, TICK, RUNNING, STEPPING;

    always #5 CLK = ~CLK;

    jclk_ctrl #(
        .BASE_HALF  (BASE),
        .STEP_CYCLES(STEPS),
        .CW         (26)
    ) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .RUN_CLICK (RUN_CLICK),
        .STEP_CLICK(STEP_CLICK),
        .HALT      (HALT),
        .SPEED     (SPEED),
        .SCLK      (SCLK),
        .TICK      (TICK),
        .RUNNING   (RUNNING),
        .STEPPING  (STEPPING)
    );

    typedef struct packed {
        logic       lvl;
        int         len;
        logic       last;
        logic [1:0] mode;
    } phase_t;

    phase_t exp_q[$];
    int     checks = 0;
    int     failures = 0;
    bit     mon_en = 1'b0;
    int     phase_no = 0;

    // Per-edge stimulus schedule; index 0 is the edge that samples the opening click.
    bit rc[SLEN];
    bit sc[SLEN];
    bit hl[SLEN];
    int sp[SLEN];

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic int hval(input int s);
        int h;
        h = BASE >> s;
        return (h == 0) ? 1 : h;
    endfunction

    function automatic void push(input logic lvl, input int len, input logic last,
                                 input logic [1:0] mode);
        phase_t p;
        p.lvl  = lvl;
        p.len  = len;
        p.last = last;
        p.mode = mode;
        exp_q.push_back(p);
    endfunction

    function automatic void build_base(input int sp0, input bit rnd);
        for (int i = 0; i < SLEN; i++) begin
            rc[i] = 1'b0;
            sc[i] = 1'b0;
            hl[i] = 1'b0;
            if (i == 0) sp[i] = sp0;
            else if (rnd && $urandom_range(0, 11) == 0) sp[i] = int'($urandom_range(0, 15));
            else sp[i] = sp[i-1];
        end
    endfunction

    // Each half-phase takes the speed present at its first edge; a stop landing inside a
    // high phase lets the matching low phase finish, inside a low phase just that phase.
    function automatic int model_run(input int stop_rel);
        int   t;
        int   h;
        logic lvl;
        t   = 0;
        lvl = 1'b1;
        for (int k = 0; k < SLEN; k++) begin
            h = hval(sp[t]);
            if (stop_rel <= t + h) begin
                if (lvl) begin
                    push(1'b1, h, 1'b0, MODE_RUN);
                    t = t + h;
                    h = hval(sp[t]);
                end
                push(1'b0, h, 1'b1, MODE_RUN);
                return t + h;
            end
            push(lvl, h, 1'b0, MODE_RUN);
            t   = t + h;
            lvl = ~lvl;
        end
        return t;
    endfunction

    function automatic int model_step();
        int t;
        int h;
        t = 0;
        for (int p = 0; p < STEPS; p++) begin
            h = hval(sp[t]);
            push(1'b1, h, 1'b0, MODE_STEP);
            t = t + h;
            h = hval(sp[t]);
            push(1'b0, h, (p == STEPS - 1), MODE_STEP);
            t = t + h;
        end
        return t;
    endfunction

    task automatic tk();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input int n);
        for (int i = 0; i < n; i++) begin
            RUN_CLICK  = rc[i];
            STEP_CLICK = sc[i];
            HALT       = hl[i];
            SPEED      = 4'(sp[i]);
            tk();
        end
        RUN_CLICK  = 1'b0;
        STEP_CLICK = 1'b0;
        HALT       = 1'b0;
    endtask

    // Monitor: measures each half-phase from level changes and the end of activity.
    logic       m_active = 1'b0;
    logic       m_lvl;
    int         m_len;
    logic [1:0] m_mode;
    logic       prev_s = 1'b0;
    logic       m_s, m_b;
    phase_t     got_p, exp_p;

    always @(negedge CLK) begin
        if (!mon_en) begin
            m_active = 1'b0;
            prev_s   = SCLK;
        end else begin
            m_s = SCLK;
            m_b = RUNNING | STEPPING;
            check("tick", int'(TICK), int'(m_s && !prev_s));
            check("sclk_while_idle", int'(m_s && !m_b), 0);
            if (m_active && m_b && m_s == m_lvl) begin
                m_len++;
            end else begin
                if (m_active) begin
                    phase_no++;
                    got_p.lvl  = m_lvl;
                    got_p.len  = m_len;
                    got_p.last = ~m_b;
                    got_p.mode = m_mode;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL phase%0d: got lvl=%0d len=%0d last=%0d mode=%0d want none",
                                 phase_no, got_p.lvl, got_p.len, got_p.last, got_p.mode);
                    end else begin
                        exp_p = exp_q.pop_front();
                        if (got_p != exp_p) begin
                            failures++;
                            $display("FAIL phase%0d: got lvl=%0d len=%0d last=%0d mode=%0d want lvl=%0d len=%0d last=%0d mode=%0d",
                                     phase_no, got_p.lvl, got_p.len, got_p.last, got_p.mode,
                                     exp_p.lvl, exp_p.len, exp_p.last, exp_p.mode);
                        end
                    end
                end
                m_active = m_b;
                m_lvl    = m_s;
                m_len    = 1;
                m_mode   = {STEPPING, RUNNING};
            end
            prev_s = m_s;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int idle;
        int highs;
        int kind;
        int stop_rel;
        bit seen;

        RESETN     = 1'b0;
        RUN_CLICK  = 1'b0;
        STEP_CLICK = 1'b0;
        HALT       = 1'b0;
        SPEED      = 4'd0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_sclk", int'(SCLK), 0);
        check("reset_tick", int'(TICK), 0);
        check("reset_running", int'(RUNNING), 0);
        check("reset_stepping", int'(STEPPING), 0);
        RESETN = 1'b1;
        highs  = 0;
        for (int i = 0; i < 50; i++) begin
            tk();
            if (SCLK !== 1'b0) highs++;
        end
        check("idle_sclk_highs", highs, 0);
        mon_en = 1'b1;
        tk();

        // Step burst at SPEED=2 with a stray STEP_CLICK mid-burst.
        build_base(2, 1'b0);
        sc[0] = 1'b1;
        idle  = model_step();
        sc[10] = 1'b1;
        drive(idle + 3);

        // Run at SPEED=0, speed change mid-high, stop click during a high phase.
        build_base(0, 1'b0);
        for (int i = 5; i < SLEN; i++) sp[i] = 3;
        rc[0]  = 1'b1;
        rc[23] = 1'b1;
        idle   = model_run(23);
        drive(idle + 3);

        // Run at SPEED=1, HALT raised during a low phase.
        build_base(1, 1'b0);
        rc[0] = 1'b1;
        idle  = model_run(12);
        for (int i = 12; i < idle + 3; i++) hl[i] = 1'b1;
        drive(idle + 3);

        // RUN_CLICK while HALT is held must not start the clock.
        build_base(0, 1'b0);
        for (int i = 0; i < 20; i++) hl[i] = 1'b1;
        rc[3] = 1'b1;
        drive(20);
        check("halt_blocks_running", int'(RUNNING), 0);
        check("halt_blocks_sclk", int'(SCLK), 0);

        // SPEED=15 clamps to one-cycle phases.
        build_base(15, 1'b0);
        rc[0] = 1'b1;
        rc[7] = 1'b1;
        idle  = model_run(7);
        drive(idle + 3);

        // Reset in the middle of a step burst while SCLK is high.
        mon_en     = 1'b0;
        SPEED      = 4'd2;
        STEP_CLICK = 1'b1;
        tk();
        STEP_CLICK = 1'b0;
        repeat (8) tk();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (SCLK === 1'b1) seen = 1'b1;
            else tk();
        end
        check("midstep_sclk_high_seen", int'(seen), 1);
        RESETN = 1'b0;
        tk();
        check("midstep_reset_sclk", int'(SCLK), 0);
        check("midstep_reset_stepping", int'(STEPPING), 0);
        check("midstep_reset_running", int'(RUNNING), 0);
        RESETN = 1'b1;
        tk();
        mon_en = 1'b1;
        tk();
        build_base(2, 1'b0);
        sc[0] = 1'b1;
        idle  = model_step();
        drive(idle + 3);

        // Randomized scenarios with random speed schedules and stray inputs.
        for (int n = 0; n < 30; n++) begin
            kind = int'($urandom_range(0, 3));
            build_base(int'($urandom_range(0, 15)), 1'b1);
            if (kind == 0) begin
                sc[0] = 1'b1;
                rc[0] = 1'($urandom_range(0, 1));
                hl[0] = 1'($urandom_range(0, 1));
                idle  = model_step();
                for (int i = 1; i <= idle; i++) begin
                    rc[i] = ($urandom_range(0, 7) == 0);
                    sc[i] = ($urandom_range(0, 7) == 0);
                    hl[i] = ($urandom_range(0, 7) == 0);
                end
                drive(idle + 2 + int'($urandom_range(0, 3)));
            end else if (kind == 3) begin
                for (int i = 0; i < 12; i++) hl[i] = 1'b1;
                rc[int'($urandom_range(0, 11))] = 1'b1;
                drive(12);
                check("rand_halt_blocks", int'(RUNNING), 0);
            end else begin
                rc[0]    = 1'b1;
                stop_rel = int'($urandom_range(1, 60));
                idle     = model_run(stop_rel);
                if (kind == 2) begin
                    for (int i = stop_rel; i < idle + 3; i++) hl[i] = 1'b1;
                end else begin
                    rc[stop_rel] = 1'b1;
                end
                for (int i = 1; i <= idle; i++) sc[i] = ($urandom_range(0, 9) == 0);
                drive(idle + 3);
            end
        end

        repeat (5) tk();
        check("scoreboard_empty", exp_q.size(), 0);
        check("monitor_idle", int'(m_active), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
